uart_mem_loader: RTL

- Memory-bus initiator fed by a UART byte stream; it is the writer counterpart to the SPRAM/BRAM responders.
- Receives 8N1 serial frames, assembles little-endian 32-bit words and issues single-cycle word writes on the pipeline-style memory bus.
- Holds the CPU until a Go command supplies the start PC.
- Sits in the board top beside the Pipeline; the top muxes its bus onto the memories while cpu_hold=1.

---
 rtl/uart_mem_loader_if.sv | 12 +
 rtl/uart_mem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader_if.sv
// Write-only memory bus driven by the UART loader.
// mem_valid is a one-cycle strobe with no ready: the target accepts every write in the cycle it is presented.
interface uart_mem_loader_if;
  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;

  modport master (output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr);
  modport slave  (input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr);
endinterface

// File: rtl/uart_mem_loader.sv
// UART 8N1 receiver plus a command parser: 'L' frames write words to memory and 'G' releases the CPU.
module uart_mem_loader #(
  parameter int CLOCK_RATE   = 12_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_i,
  uart_mem_loader_if.master       bus,
  output logic                    cpu_hold_o,
  output logic [31:0]             start_pc_o,
  output logic                    done_o,
  output logic                    frame_err_o,
  output logic [4:0]              dbg_state_o
);
  localparam int DIV  = CLOCK_RATE / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_LEN, P_DATA, P_GO} p_state_t;

  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_meta_q, rx_sync_q;
  logic          byte_valid_q, byte_valid_d;
  logic          rx_err_q, rx_err_d;

  p_state_t p_state_q, p_state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]             shift_q, shift_d, shifted;
  logic [31:0]             addr_q, addr_d;
  logic [15:0]             len_q, len_d;
  logic [TIMEOUT_BITS-1:0] gap_q, gap_d;
  logic                    valid_q, valid_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             out_addr_q, out_addr_d;
  logic                    done_q, done_d;
  logic                    ferr_q, ferr_d;
  logic [31:0]             start_pc_q, start_pc_d;
  logic                    hold_q, hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      rx_meta_q    <= rx_i;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      rx_err_q     <= rx_err_d;
    end
  end

  // Start bit is re-checked at mid-bit so short glitches never become bytes.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    rx_err_d     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CW'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CW'(DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CW'(DIV - 1)) begin
          rx_cnt_d     = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync_q;
          rx_err_d     = !rx_sync_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state_q  <= P_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      valid_q    <= 1'b0;
      wdata_q    <= '0;
      out_addr_q <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      start_pc_q <= '0;
      hold_q     <= 1'b1;
    end else begin
      p_state_q  <= p_state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      valid_q    <= valid_d;
      wdata_q    <= wdata_d;
      out_addr_q <= out_addr_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      start_pc_q <= start_pc_d;
      hold_q     <= hold_d;
    end
  end

  // Bytes enter at the top so the first one received ends up least significant.
  assign shifted = {rx_shift_q, shift_q[31:8]};

  always_comb begin
    p_state_d  = p_state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    len_d      = len_q;
    gap_d      = gap_q;
    valid_d    = 1'b0;
    wdata_d    = wdata_q;
    out_addr_d = out_addr_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    start_pc_d = start_pc_q;
    hold_d     = hold_q;
    if (rx_err_q) begin
      ferr_d     = 1'b1;
      gap_d      = '0;
      byte_cnt_d = '0;
      p_state_d  = P_IDLE;
    end else if (byte_valid_q) begin
      gap_d      = '0;
      shift_d    = shifted;
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (p_state_q)
        P_IDLE: begin
          byte_cnt_d = '0;
          if (rx_shift_q == 8'h4C) p_state_d = P_ADDR;
          else if (rx_shift_q == 8'h47) p_state_d = P_GO;
        end
        P_ADDR: if (byte_cnt_q == 2'd3) begin
          addr_d     = {shifted[31:2], 2'b00};
          byte_cnt_d = '0;
          p_state_d  = P_LEN;
        end
        P_LEN: if (byte_cnt_q == 2'd1) begin
          len_d      = shifted[31:16];
          byte_cnt_d = '0;
          if (shifted[31:16] == 16'd0) begin
            done_d    = 1'b1;
            p_state_d = P_IDLE;
          end else begin
            p_state_d = P_DATA;
          end
        end
        P_DATA: if (byte_cnt_q == 2'd3) begin
          valid_d    = 1'b1;
          wdata_d    = shifted;
          out_addr_d = addr_q;
          addr_d     = addr_q + 32'd4;
          len_d      = len_q - 16'd1;
          if (len_q == 16'd1) begin
            done_d    = 1'b1;
            p_state_d = P_IDLE;
          end
        end
        P_GO: if (byte_cnt_q == 2'd3) begin
          start_pc_d = shifted;
          hold_d     = 1'b0;
          p_state_d  = P_IDLE;
        end
        default: p_state_d = P_IDLE;
      endcase
    end else if (p_state_q != P_IDLE) begin
      if (gap_q == '1) begin
        ferr_d     = 1'b1;
        gap_d      = '0;
        byte_cnt_d = '0;
        p_state_d  = P_IDLE;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_write = valid_q;
  assign bus.mem_wmask = valid_q ? 4'hF : 4'h0;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_addr  = out_addr_q;
  assign cpu_hold_o    = hold_q;
  assign start_pc_o    = start_pc_q;
  assign done_o        = done_q;
  assign frame_err_o   = ferr_q;
  assign dbg_state_o   = {rx_state_q, p_state_q};
endmodule
